// File: rtl/imem_loader.sv
// imem_loader: assembles a big-endian byte stream into 32-bit words for instruction memory
// and holds the CPU in reset until the load completes. Optional macro: IMEM_LOADER_CHECKSUM_EN.
module imem_loader #(
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
  parameter int unsigned MAX_WORDS = 256,
  parameter int unsigned CNT_W     = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [CNT_W-1:0] num_words,
  input  logic [7:0]       byte_in,
  input  logic             byte_valid,
  output logic             byte_ready,
  output logic             imem_we,
  output logic [31:0]      imem_addr,
  output logic [31:0]      imem_wdata,
  output logic             cpu_hold,
  output logic             busy,
  output logic             done,
  output logic             error
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
`ifdef IMEM_LOADER_CHECKSUM_EN
    S_CHECK,
`endif
    S_DONE,
    S_ERROR
  } state_e;

  state_e           state_q, state_d;
  logic [1:0]       byte_cnt_q, byte_cnt_d;
  logic [CNT_W-1:0] word_cnt_q, word_cnt_d;
  logic [CNT_W-1:0] num_q, num_d;
  logic [23:0]      shift_q, shift_d;
  logic [31:0]      addr_q, addr_d;
  logic [31:0]      wdata_q, wdata_d;
  logic             we_q, we_d;
  logic             byte_ready_q, byte_ready_d;
  logic             cpu_hold_q, cpu_hold_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             error_q, error_d;
`ifdef IMEM_LOADER_CHECKSUM_EN
  logic [7:0]       xor_q, xor_d;
`endif

  logic accept;
  assign accept = byte_valid && byte_ready_q;

  always_comb begin
    // NOTE: every combinational output is defaulted first so no branch can infer a latch.
    state_d    = state_q;
    byte_cnt_d = byte_cnt_q;
    word_cnt_d = word_cnt_q;
    num_d      = num_q;
    shift_d    = shift_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    we_d       = 1'b0;
`ifdef IMEM_LOADER_CHECKSUM_EN
    xor_d      = xor_q;
`endif

    case (state_q)
      S_LOAD: begin
        // Reaching num_q here means the final write cycle has just been spent.
        if (word_cnt_q == num_q) begin
          state_d = S_DONE;
        end else if (accept) begin
          shift_d    = {shift_q[15:0], byte_in};
          byte_cnt_d = byte_cnt_q + 2'd1;
`ifdef IMEM_LOADER_CHECKSUM_EN
          xor_d      = xor_q ^ byte_in;
`endif
          if (byte_cnt_q == 2'd3) begin
            we_d       = 1'b1;
            addr_d     = BASE_ADDR + (32'(word_cnt_q) << 2);
            wdata_d    = {shift_q, byte_in};
            word_cnt_d = word_cnt_q + CNT_W'(1);
`ifdef IMEM_LOADER_CHECKSUM_EN
            if (word_cnt_d == num_q) state_d = S_CHECK;
`endif
          end
        end
      end
`ifdef IMEM_LOADER_CHECKSUM_EN
      S_CHECK: begin
        if (accept) state_d = (byte_in == xor_q) ? S_DONE : S_ERROR;
      end
`endif
      default: begin
        if (start) begin
          num_d      = num_words;
          word_cnt_d = '0;
          byte_cnt_d = 2'd0;
`ifdef IMEM_LOADER_CHECKSUM_EN
          xor_d      = 8'h00;
`endif
          if (num_words == '0)                   state_d = S_DONE;
          else if (32'(num_words) > MAX_WORDS)   state_d = S_ERROR;
          else                                   state_d = S_LOAD;
        end
      end
    endcase

    // Outputs are registered copies of what the next state implies.
`ifdef IMEM_LOADER_CHECKSUM_EN
    busy_d = (state_d == S_LOAD) || (state_d == S_CHECK);
`else
    busy_d = (state_d == S_LOAD);
`endif
    byte_ready_d = busy_d && !((state_d == S_LOAD) && (word_cnt_d == num_d));
    done_d       = (state_d == S_DONE);
    error_d      = (state_d == S_ERROR);
    cpu_hold_d   = (state_d != S_DONE);
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      byte_cnt_q   <= 2'd0;
      word_cnt_q   <= '0;
      num_q        <= '0;
      shift_q      <= '0;
      addr_q       <= BASE_ADDR;
      wdata_q      <= '0;
      we_q         <= 1'b0;
      byte_ready_q <= 1'b0;
      cpu_hold_q   <= 1'b1;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      error_q      <= 1'b0;
`ifdef IMEM_LOADER_CHECKSUM_EN
      xor_q        <= 8'h00;
`endif
    end else begin
      state_q      <= state_d;
      byte_cnt_q   <= byte_cnt_d;
      word_cnt_q   <= word_cnt_d;
      num_q        <= num_d;
      shift_q      <= shift_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
      we_q         <= we_d;
      byte_ready_q <= byte_ready_d;
      cpu_hold_q   <= cpu_hold_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      error_q      <= error_d;
`ifdef IMEM_LOADER_CHECKSUM_EN
      xor_q        <= xor_d;
`endif
    end
  end

  assign byte_ready = byte_ready_q;
  assign imem_we    = we_q;
  assign imem_addr  = addr_q;
  assign imem_wdata = wdata_q;
  assign cpu_hold   = cpu_hold_q;
  assign busy       = busy_q;
  assign done       = done_q;
  assign error      = error_q;

endmodule

// File: tb/tb_imem_loader.sv
// Self-checking bench for imem_loader: vector table, reset/checksum sequences, random loads
// compared against a word-list model of the expected instruction-memory writes.
module tb_imem_loader;
  localparam int unsigned CNT_W     = 16;
  localparam int unsigned MAX_WORDS = 256;
  localparam logic [31:0] BASE      = 32'h0000_0000;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             start = 1'b0;
  logic [CNT_W-1:0] num_words = '0;
  logic [7:0]       byte_in = 8'h00;
  logic             byte_valid = 1'b0;
  logic             byte_ready, imem_we, cpu_hold, busy, done, error;
  logic [31:0]      imem_addr, imem_wdata;

  imem_loader #(.BASE_ADDR(BASE), .MAX_WORDS(MAX_WORDS), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .num_words(num_words),
    .byte_in(byte_in), .byte_valid(byte_valid), .byte_ready(byte_ready),
    .imem_we(imem_we), .imem_addr(imem_addr), .imem_wdata(imem_wdata),
    .cpu_hold(cpu_hold), .busy(busy), .done(done), .error(error)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct { logic [31:0] addr; logic [31:0] data; int cyc; } wr_t;
  wr_t wr_q[$];
  always @(negedge clk) if (rst_n && imem_we) wr_q.push_back('{imem_addr, imem_wdata, cyc});

  int checks = 0;
  int failures = 0;
  logic [7:0] stim_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // Data bytes for n words, optionally followed by a (good or bad) checksum byte.
  task automatic build_random(input int n);
    stim_q.delete();
    for (int i = 0; i < 4 * n; i++) stim_q.push_back(8'($urandom));
  endtask

  task automatic add_cksum(input bit good);
`ifdef IMEM_LOADER_CHECKSUM_EN
    logic [7:0] x = 8'h00;
    foreach (stim_q[i]) x ^= stim_q[i];
    stim_q.push_back(good ? x : ~x);
`endif
  endtask

  function automatic bit cksum_matters();
`ifdef IMEM_LOADER_CHECKSUM_EN
    return 1'b1;
`else
    return 1'b0;
`endif
  endfunction

  task automatic start_pulse(input logic [15:0] nw);
    @(negedge clk);
    start = 1'b1; num_words = nw;
    @(negedge clk);
    start = 1'b0; num_words = 16'($urandom);
  endtask

  // Sends stim_q[0 .. count-1]; gap_mode 0 = back-to-back, 1 = toggle, 2 = random gaps.
  task automatic stream(input int count, input int gap_mode, input bit poke);
    for (int i = 0; i < count; i++) begin
      bit acc = 1'b0;
      bit gap = (gap_mode == 1) || (gap_mode == 2 && $urandom_range(0, 2) == 0);
      if (gap) begin
        byte_valid = 1'b0;
        @(negedge clk);
      end
      byte_in = stim_q[i]; byte_valid = 1'b1;
      if (poke && i == 5) begin start = 1'b1; num_words = '0; end
      for (int t = 0; t < 20 && !acc; t++) begin
        acc = byte_ready;
        @(negedge clk);
        start = 1'b0;
      end
      if (!acc) begin
        check("accept_timeout", 32'd1, 32'd0);
        break;
      end
    end
    byte_valid = 1'b0;
  endtask

  task automatic run_load(input string tag, input logic [15:0] nw, input int gap_mode,
                          input bit poke, input bit exp_ok);
    int n = int'(nw);
    bit legal = (n <= int'(MAX_WORDS));
    int exp_writes = legal ? n : 0;
    bit exp_done = legal && (exp_ok || !cksum_matters() || n == 0);
    int done_cyc = -1;
    int nwr;
    wr_q.delete();
    start_pulse(nw);
    if (n == 0) begin
      check({tag, "_zero_done"}, done, 1);
    end else if (!legal) begin
      check({tag, "_err_now"}, error, 1);
      check({tag, "_err_rdy"}, byte_ready, 0);
    end else begin
      check({tag, "_s1_busy"}, busy, 1);
      check({tag, "_s1_rdy"}, byte_ready, 1);
      stream(stim_q.size(), gap_mode, poke);
    end
    for (int t = 0; t < 20 && done_cyc < 0; t++) begin
      if (done || error) done_cyc = cyc;
      else @(negedge clk);
    end
    if (done_cyc < 0) check({tag, "_finish_timeout"}, 32'd1, 32'd0);
    repeat (2) @(negedge clk);
    check({tag, "_done"}, done, exp_done);
    check({tag, "_error"}, error, !exp_done);
    check({tag, "_hold"}, cpu_hold, !exp_done);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_rdy"}, byte_ready, 0);
    check({tag, "_nwrites"}, wr_q.size(), exp_writes);
    nwr = (wr_q.size() < exp_writes) ? wr_q.size() : exp_writes;
    for (int k = 0; k < nwr; k++) begin
      check({tag, "_addr"}, wr_q[k].addr, BASE + 32'(4 * k));
      check({tag, "_data"}, wr_q[k].data,
            {stim_q[4*k], stim_q[4*k+1], stim_q[4*k+2], stim_q[4*k+3]});
    end
    if (gap_mode == 0 && exp_done && exp_writes > 0 && nwr > 0)
      check({tag, "_done_lat"}, 32'(done_cyc - wr_q[nwr-1].cyc), 32'd1);
    // A byte offered while idle must not be consumed or written.
    nwr = wr_q.size();
    byte_in = 8'h5A; byte_valid = 1'b1;
    repeat (3) @(negedge clk);
    byte_valid = 1'b0;
    check({tag, "_idle_nowrite"}, wr_q.size(), nwr);
  endtask

  typedef struct {
    string       tag;
    logic [15:0] nw;
    int          gap_mode;
    bit          poke;
    bit          fixed;
  } vec_t;

  vec_t vecs[6];
  localparam logic [63:0] FIXED = 64'h1234_5678_9ABC_DEF0;

  initial begin
    vecs[0] = '{"b2b",    16'd2,   0, 1'b0, 1'b1};
    vecs[1] = '{"toggle", 16'd2,   1, 1'b0, 1'b1};
    vecs[2] = '{"zero",   16'd0,   0, 1'b0, 1'b0};
    vecs[3] = '{"toobig", 16'd257, 0, 1'b0, 1'b0};
    vecs[4] = '{"poke",   16'd3,   2, 1'b1, 1'b0};
    vecs[5] = '{"max",    16'd256, 0, 1'b0, 1'b0};

    // Reset state.
    #12;
    check("rst_hold", cpu_hold, 1);
    check("rst_we", imem_we, 0);
    check("rst_rdy", byte_ready, 0);
    check("rst_addr", imem_addr, BASE);
    check("rst_wdata", imem_wdata, 0);
    check("rst_flags", {29'd0, done, error, busy}, 0);
    @(negedge clk); rst_n = 1'b1;

    foreach (vecs[v]) begin
      logic [63:0] f = FIXED;
      if (vecs[v].fixed) begin
        stim_q.delete();
        for (int i = 0; i < 8; i++) stim_q.push_back(f[63-8*i -: 8]);
      end else begin
        build_random((int'(vecs[v].nw) <= int'(MAX_WORDS)) ? int'(vecs[v].nw) : 0);
      end
      if (vecs[v].nw != 0 && int'(vecs[v].nw) <= int'(MAX_WORDS)) add_cksum(1'b1);
      run_load(vecs[v].tag, vecs[v].nw, vecs[v].gap_mode, vecs[v].poke, 1'b1);
    end

    // Reset asserted after 6 of 8 bytes, then a fresh one-word load.
    begin
      logic [63:0] f = FIXED;
      stim_q.delete();
      for (int i = 0; i < 8; i++) stim_q.push_back(f[63-8*i -: 8]);
      start_pulse(16'd2);
      stream(6, 0, 1'b0);
      rst_n = 1'b0;
      #1;
      check("mid_rst_hold", cpu_hold, 1);
      check("mid_rst_we", imem_we, 0);
      check("mid_rst_rdy", byte_ready, 0);
      check("mid_rst_addr", imem_addr, BASE);
      check("mid_rst_flags", {29'd0, done, error, busy}, 0);
      @(negedge clk); rst_n = 1'b1;
      stim_q = '{8'hAA, 8'hBB, 8'hCC, 8'hDD};
      add_cksum(1'b1);
      run_load("fresh", 16'd1, 0, 1'b0, 1'b1);
    end

`ifdef IMEM_LOADER_CHECKSUM_EN
    stim_q = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h0F};
    run_load("ck_good", 16'd1, 0, 1'b0, 1'b1);
    stim_q = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h0E};
    run_load("ck_bad", 16'd1, 0, 1'b0, 1'b0);
`endif

    // Random loads against the word-list model.
    for (int r = 0; r < 8; r++) begin
      int n = $urandom_range(1, 5);
      bit good = ($urandom_range(0, 3) != 0);
      build_random(n);
      add_cksum(good);
      run_load($sformatf("rnd%0d", r), 16'(n), 2, 1'b0, good);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL global_timeout: got timeout expected completion");
    $fatal(1, "timeout");
  end
endmodule

// File: doc/imem_loader.md
# imem_loader

Boot-time program loader that sits directly upstream of the single-cycle CPU's instruction memory. It accepts a byte stream over a valid/ready handshake and assembles big-endian 32-bit instruction words. Each word is written into instruction memory at consecutive word addresses. The CPU is held in reset until the requested number of words has been written, then released.

## Interface
Parameters:
- BASE_ADDR, 32'h0000_0000, byte address of the first instruction word written
- MAX_WORDS, 256, largest accepted load length in words
- CNT_W, 16, width of the word counter and of `num_words`

Ports:
- clk  in  1  system clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- start  in  1  one-cycle pulse that begins a load
- num_words  in  CNT_W  number of words to load, sampled when `start` is accepted
- byte_in  in  8  stream data
- byte_valid  in  1  `byte_in` is valid
- byte_ready  out  1  loader accepts a byte this cycle
- imem_we  out  1  instruction-memory write strobe, one cycle per word
- imem_addr  out  32  instruction-memory byte address, word aligned
- imem_wdata  out  32  assembled instruction word
- cpu_hold  out  1  holds the CPU/PC in reset while high
- busy  out  1  a load is in progress
- done  out  1  last load completed successfully
- error  out  1  last load was rejected

## Operation
- Reset values:
  - cpu_hold=1
  - byte_ready=0, imem_we=0, busy=0, done=0, error=0
  - imem_addr=BASE_ADDR, imem_wdata=0
  - state IDLE, byte count 0, word count 0
- A byte is accepted only on a cycle where `byte_valid && byte_ready`.
- All outputs are registered.
- States:
  - IDLE:
    - `start` with `num_words` = 0 → DONE.
    - `start` with `num_words` > MAX_WORDS → ERROR.
    - Any other `start` → LOAD.
  - LOAD:
    - byte_ready=1, busy=1, cpu_hold=1.
    - Bytes are shifted in big-endian: the first byte lands in [31:24].
    - When the 4th byte of a word is accepted, the assembled word is written and the word count increments.
    - After the last word → DONE, or → CHECK when the checksum feature is compiled in.
  - CHECK: see Configuration.
  - DONE: done=1, cpu_hold=0, busy=0, byte_ready=0.
  - ERROR: error=1, cpu_hold=1, busy=0, byte_ready=0.
- `start` in DONE or ERROR:
  - clears done and error;
  - restarts with the same rules as in IDLE;
  - reasserts cpu_hold in the following cycle.
- `start` in LOAD or CHECK is ignored.
- Write address for word k = BASE_ADDR + 4·k, 32-bit wrap-around, no overflow flag.
- Bytes presented while byte_ready=0 are not consumed.
- Reset mid-load:
  - returns immediately to the reset values;
  - partial words are discarded;
  - words already written stay in memory.

## Timing
- 4th byte of a word accepted at edge N → imem_we=1 with imem_addr/imem_wdata valid during cycle N+1, for exactly one cycle.
- byte_ready stays 1 during the write cycle, so back-to-back bytes sustain 1 byte/cycle (1 word per 4 cycles).
- Gaps in byte_valid stall assembly with no side effects.
- Last word written in cycle N+1 → done=1 and cpu_hold=0 from cycle N+2. The CPU never runs while a write is pending.
- `start` at edge S → busy=1 and byte_ready=1 from cycle S+1.
- `num_words` = 0 → done=1 at S+1, with no writes.
- Error on start → error=1 at S+1, with no writes.

## Configuration
- Macro `IMEM_LOADER_CHECKSUM_EN`.
- Defined:
  - A running XOR of all accepted data bytes is kept.
  - After the last word, the loader enters CHECK (byte_ready=1) and accepts exactly one checksum byte.
  - Match → DONE one cycle after acceptance.
  - Mismatch → ERROR; memory contents are left as written and cpu_hold stays 1.
- Undefined: no CHECK state and no XOR register; LOAD goes directly to DONE.

## Test plan
- Reset: rst_n=0 → cpu_hold=1, imem_we=0, byte_ready=0, imem_addr=0, done=error=busy=0.
- start, num_words=2, bytes 12 34 56 78 9A BC DE F0 back-to-back:
  - write 0x12345678 @0x0, then 0x9ABCDEF0 @0x4, each imem_we one cycle;
  - done=1 and cpu_hold=0 one cycle after the second write.
- Same load with byte_valid toggling every other cycle → identical writes and addresses, no extra imem_we pulses.
- num_words=0 → done=1 next cycle, no writes.
- num_words=MAX_WORDS+1 → error=1, cpu_hold=1, byte_ready stays 0.
- rst_n pulsed low after 6 of 8 bytes → immediate reset values. A fresh load of 1 word (AA BB CC DD) then writes 0xAABBCCDD @0x0.
- With IMEM_LOADER_CHECKSUM_EN, 1 word 01 02 04 08:
  - checksum 0x0F → done=1;
  - checksum 0x0E → error=1, cpu_hold=1.
